// File: rtl/rv_ctrl_pkg.sv
// rtl/rv_ctrl_pkg.sv - shared encodings for the multicycle RV32I control path
package rv_ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXEC   = 4'd6,
        EXECI  = 4'd7,
        ALUWB  = 4'd8,
        BRANCH = 4'd9
    } state_t;

    // Supported major opcodes (instruction[6:0])
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    // ALUOp encodings, shared with the ALU control decoder
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // ALU B operand select
    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_FOUR = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;
    localparam logic [1:0] SRCB_BIMM = 2'b11;

endpackage

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - main control FSM for the multicycle RV32I datapath
module multicycle_control
    import rv_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [6:0]       Opcode,
    input  logic             MemReady,
    output logic             PCWrite,
    output logic             PCWriteCond,
    output logic             IorD,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             MemtoReg,
    output logic             RegWrite,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ALUOp,
    output logic             PCSource,
    output logic             IllegalInstr,
    output logic [CNT_W-1:0] InstrCount
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t state;
    state_t state_next;
    logic   retire;

    // State register and retired-instruction counter; reset wins over everything
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= FETCH;
            InstrCount <= '0;
        end else begin
            state <= state_next;
            if (retire) begin
                InstrCount <= InstrCount + CNT_ONE;
            end
        end
    end

    // Next-state decode; retire marks the transitions that complete an instruction
    always_comb begin
        state_next = state;
        retire     = 1'b0;
        case (state)
            FETCH: begin
                if (MemReady) begin
                    state_next = DECODE;
                end
            end
            DECODE: begin
                case (Opcode)
                    OPC_LOAD, OPC_STORE: state_next = MEMADR;
                    OPC_OP:              state_next = EXEC;
                    OPC_OPIMM:           state_next = EXECI;
                    OPC_BRANCH:          state_next = BRANCH;
                    default:             state_next = FETCH;
                endcase
            end
            MEMADR: begin
                // The IR holds the opcode, so LOAD vs STORE is still visible here
                state_next = (Opcode == OPC_LOAD) ? MEMRD : MEMWR;
            end
            MEMRD: begin
                if (MemReady) begin
                    state_next = MEMWB;
                end
            end
            MEMWB: begin
                state_next = FETCH;
                retire     = 1'b1;
            end
            MEMWR: begin
                if (MemReady) begin
                    state_next = FETCH;
                    retire     = 1'b1;
                end
            end
            EXEC:  state_next = ALUWB;
            EXECI: state_next = ALUWB;
            ALUWB: begin
                state_next = FETCH;
                retire     = 1'b1;
            end
            BRANCH: begin
                state_next = FETCH;
                retire     = 1'b1;
            end
            default: state_next = FETCH;
        endcase
    end

    // Moore output decode; only the FETCH load strobes look at MemReady
    always_comb begin
        PCWrite      = 1'b0;
        PCWriteCond  = 1'b0;
        IorD         = 1'b0;
        MemRead      = 1'b0;
        MemWrite     = 1'b0;
        IRWrite      = 1'b0;
        MemtoReg     = 1'b0;
        RegWrite     = 1'b0;
        ALUSrcA      = 1'b0;
        ALUSrcB      = SRCB_RS2;
        ALUOp        = ALUOP_ADD;
        PCSource     = 1'b0;
        IllegalInstr = 1'b0;
        case (state)
            FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = SRCB_FOUR;
                IRWrite = MemReady;
                PCWrite = MemReady;
            end
            DECODE: begin
                ALUSrcB = SRCB_BIMM;
                case (Opcode)
                    OPC_LOAD, OPC_STORE, OPC_OP, OPC_OPIMM, OPC_BRANCH: IllegalInstr = 1'b0;
                    default:                                            IllegalInstr = 1'b1;
                endcase
            end
            MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
            end
            MEMRD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
            end
            MEMWB: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
            end
            MEMWR: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
            end
            EXEC: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_RS2;
                ALUOp   = ALUOP_FUNCT;
            end
            EXECI: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
            end
            ALUWB: begin
                RegWrite = 1'b1;
            end
            BRANCH: begin
                ALUSrcA     = 1'b1;
                ALUSrcB     = SRCB_RS2;
                ALUOp       = ALUOP_SUB;
                PCWriteCond = 1'b1;
                PCSource    = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - scoreboard bench for multicycle_control
module tb_multicycle_control;

    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [6:0]    Opcode;
    logic          MemReady;
    logic          PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
    logic          MemtoReg, RegWrite, ALUSrcA, PCSource, IllegalInstr;
    logic [1:0]    ALUSrcB, ALUOp;
    logic [CW-1:0] InstrCount;

    multicycle_control #(.CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .Opcode(Opcode), .MemReady(MemReady),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
        .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .MemtoReg(MemtoReg), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSource(PCSource),
        .IllegalInstr(IllegalInstr), .InstrCount(InstrCount)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic pcw, pcwc, iord, mr, mw, irw, m2r, rw, asa;
        logic [1:0] asb, aop;
        logic pcs, ill;
        logic [CW-1:0] cnt;
    } obs_t;

    typedef struct {
        string name;
        obs_t  exp;
    } item_t;

    item_t q[$];
    int    n_checks = 0;
    int    n_pass   = 0;
    int    model_cnt = 0;

    obs_t act;
    assign act = '{PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
                   RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, IllegalInstr, InstrCount};

    // Monitor: one expected observation per cycle, compared away from the rising edge
    always @(negedge clk) begin
        if (q.size() > 0) begin
            item_t it;
            it = q.pop_front();
            n_checks++;
            if (act === it.exp) n_pass++;
            else $display("FAIL %s: got %b, want %b", it.name, act, it.exp);
        end
    end

    // Expected control word for one cycle of a named phase
    function automatic obs_t expect_of(string ph, logic mrdy);
        obs_t e;
        e = '0;
        e.cnt = model_cnt[CW-1:0];
        case (ph)
            "FETCH":      begin e.mr = 1; e.asb = 2'b01; e.irw = mrdy; e.pcw = mrdy; end
            "DECODE":     begin e.asb = 2'b11; end
            "DECODE_ILL": begin e.asb = 2'b11; e.ill = 1; end
            "MEMADR":     begin e.asa = 1; e.asb = 2'b10; end
            "MEMRD":      begin e.mr = 1; e.iord = 1; end
            "MEMWB":      begin e.rw = 1; e.m2r = 1; end
            "MEMWR":      begin e.mw = 1; e.iord = 1; end
            "EXEC":       begin e.asa = 1; e.aop = 2'b10; end
            "EXECI":      begin e.asa = 1; e.asb = 2'b10; end
            "ALUWB":      begin e.rw = 1; end
            "BRANCH":     begin e.asa = 1; e.aop = 2'b01; e.pcwc = 1; e.pcs = 1; end
            default:      ;
        endcase
        return e;
    endfunction

    // One clock cycle: drive MemReady, queue the expectation, advance
    task automatic cyc(input string ph, input logic mrdy, input bit retires);
        item_t it;
        MemReady = mrdy;
        it.name = ph;
        it.exp  = expect_of(ph, mrdy);
        q.push_back(it);
        @(posedge clk);
        #1;
        if (retires) model_cnt = (model_cnt + 1) % (1 << CW);
    endtask

    task automatic mem_wait(input string ph, input int waits, input bit retires);
        for (int i = 0; i < waits; i++) cyc(ph, 1'b0, 1'b0);
        cyc(ph, 1'b1, retires);
    endtask

    // kind: 0 lw, 1 sw, 2 R-type, 3 addi, 4 beq, 5 illegal
    task automatic run_instr(input int kind, input int fw, input int mw);
        logic [6:0] op;
        case (kind)
            0: op = 7'b0000011;
            1: op = 7'b0100011;
            2: op = 7'b0110011;
            3: op = 7'b0010011;
            4: op = 7'b1100011;
            default: begin
                do op = 7'($urandom_range(0, 127));
                while (op == 7'b0000011 || op == 7'b0100011 || op == 7'b0110011 ||
                       op == 7'b0010011 || op == 7'b1100011);
            end
        endcase
        Opcode = op;
        mem_wait("FETCH", fw, 1'b0);
        cyc(kind == 5 ? "DECODE_ILL" : "DECODE", 1'($urandom), 1'b0);
        case (kind)
            0: begin
                cyc("MEMADR", 1'($urandom), 1'b0);
                mem_wait("MEMRD", mw, 1'b0);
                cyc("MEMWB", 1'($urandom), 1'b1);
            end
            1: begin
                cyc("MEMADR", 1'($urandom), 1'b0);
                mem_wait("MEMWR", mw, 1'b1);
            end
            2: begin
                cyc("EXEC", 1'($urandom), 1'b0);
                cyc("ALUWB", 1'($urandom), 1'b1);
            end
            3: begin
                cyc("EXECI", 1'($urandom), 1'b0);
                cyc("ALUWB", 1'($urandom), 1'b1);
            end
            4: cyc("BRANCH", 1'($urandom), 1'b1);
            default: ;
        endcase
    endtask

    initial begin
        rst_n    = 1'b0;
        Opcode   = 7'd0;
        MemReady = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_cnt = 0;

        // Directed: reset state, R-type, lw with waits, beq, illegal
        run_instr(2, 0, 0);
        run_instr(0, 0, 2);
        run_instr(4, 0, 0);
        run_instr(5, 0, 0);
        run_instr(1, 1, 1);
        run_instr(3, 2, 0);

        // Reset during a store wait: next cycle is FETCH with a cleared counter
        Opcode = 7'b0100011;
        cyc("FETCH", 1'b1, 1'b0);
        cyc("DECODE", 1'b0, 1'b0);
        cyc("MEMADR", 1'b1, 1'b0);
        cyc("MEMWR", 1'b0, 1'b0);
        rst_n = 1'b0;
        cyc("MEMWR", 1'b0, 1'b0);
        rst_n = 1'b1;
        model_cnt = 0;
        cyc("FETCH", 1'b0, 1'b0);

        // Counter wrap: 15 addi to reach 15, then 2 more for 15->0->1
        for (int i = 0; i < 17; i++) run_instr(3, 0, 0);

        // Randomized mix
        for (int i = 0; i < 150; i++)
            run_instr($urandom_range(0, 5), $urandom_range(0, 2), $urandom_range(0, 3));

        @(negedge clk);
        #1;
        n_checks++;
        if (q.size() == 0) n_pass++;
        else $display("FAIL queue_drain: got %0d left, want 0", q.size());

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
